// File: rtl/apb_pkg.sv
// Shared APB master types and default sizing.
// The optional ACCESS-phase timeout is enabled with the APB_TIMEOUT_EN macro.
package apb_pkg;

  localparam int unsigned APB_ADDR_W      = 32;
  localparam int unsigned APB_DATA_W      = 32;
  localparam int unsigned APB_TIMEOUT_CYC = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_timeout.sv
// ACCESS-phase wait counter for apb_master.
// Built only when APB_TIMEOUT_EN is defined.
`ifdef APB_TIMEOUT_EN
module apb_timeout
  import apb_pkg::*;
#(
  parameter int unsigned LIMIT = APB_TIMEOUT_CYC
) (
  input  logic pClk,
  input  logic pReset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the stalled edge that would bring the count to LIMIT.
  assign expired_o = inc_i && (cnt_q == CNT_W'(LIMIT - 1));

endmodule
`endif

// File: rtl/apb_master.sv
// Single-outstanding APB master: command/response front end, registered APB outputs.
// Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC stalled cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned TIMEOUT_CYC = APB_TIMEOUT_CYC
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              pSel,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddr,
  output logic [DATA_W-1:0] pWdata,
  input  logic [DATA_W-1:0] pRdata,
  input  logic              pReady,
  input  logic              pSlvErr
);

  apb_state_e        state_q, state_d;
  logic              ready_q, ready_d;
  logic              sel_q, sel_d;
  logic              en_q, en_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              access_timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .pClk     (pClk),
    .pReset   (pReset),
    .clear_i  (state_q == SETUP),
    .inc_i    ((state_q == ACCESS) && !pReady),
    .expired_o(access_timeout)
  );
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign access_timeout     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && ready_q) begin
          state_d = SETUP;
          write_d = cmd_write;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        // pReady is checked first so a completion on the limit cycle is not an error.
        if (pReady) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = write_q ? '0 : pRdata;
          err_d    = pSlvErr;
        end else if (access_timeout) begin
          state_d  = IDLE;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are derived from the next state so they leave the flops aligned with it.
    ready_d = (state_d == IDLE);
    sel_d   = (state_d != IDLE);
    en_d    = (state_d == ACCESS);
  end

  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      sel_q    <= 1'b0;
      en_q     <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      sel_q    <= sel_d;
      en_q     <= en_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign pSel      = sel_q;
  assign pEnable   = en_q;
  assign pWrite    = write_q;
  assign pAddr     = addr_q;
  assign pWdata    = wdata_q;
  assign rsp_valid = rvalid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_error = err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with hand-computed expectations.
// The timeout scenarios run only when APB_TIMEOUT_EN is defined.
module tb_apb_master;

  logic        pClk = 1'b0;
  logic        pReset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        pSel, pEnable, pWrite;
  logic [31:0] pAddr, pWdata;
  logic [31:0] pRdata = '0;
  logic        pReady = 1'b0;
  logic        pSlvErr = 1'b0;

  int unsigned checks = 0;
  int unsigned errors = 0;

  apb_master #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .TIMEOUT_CYC(16)
  ) dut (
    .pClk     (pClk),
    .pReset   (pReset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .pSel     (pSel),
    .pEnable  (pEnable),
    .pWrite   (pWrite),
    .pAddr    (pAddr),
    .pWdata   (pWdata),
    .pRdata   (pRdata),
    .pReady   (pReady),
    .pSlvErr  (pSlvErr)
  );

  always #5 pClk = ~pClk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drives one command from a negedge where the master is idle; waits = stalled ACCESS cycles.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int unsigned waits, input logic serr);
    chk({tag, ".ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    @(negedge pClk);
    cmd_valid = 1'b0;
    chk({tag, ".setup_sel"}, pSel, 1);
    chk({tag, ".setup_en"}, pEnable, 0);
    chk({tag, ".setup_addr"}, pAddr, addr);
    chk({tag, ".setup_write"}, pWrite, wr);
    if (wr) chk({tag, ".setup_wdata"}, pWdata, wdata);
    chk({tag, ".setup_ready"}, cmd_ready, 0);
    pReady = (waits == 0); pRdata = rdata; pSlvErr = serr;
    @(negedge pClk);
    chk({tag, ".acc_sel"}, pSel, 1);
    chk({tag, ".acc_en"}, pEnable, 1);
    chk({tag, ".acc_addr"}, pAddr, addr);
    for (int unsigned i = 0; i < waits; i++) begin
      @(negedge pClk);
      chk({tag, ".wait_en"}, pEnable, 1);
      chk({tag, ".wait_addr"}, pAddr, addr);
      chk({tag, ".wait_rsp"}, rsp_valid, 0);
      pReady = (i + 1 == waits);
    end
    @(negedge pClk);
    pReady = 1'b0; pSlvErr = 1'b0;
    chk({tag, ".rsp_valid"}, rsp_valid, 1);
    chk({tag, ".rsp_rdata"}, rsp_rdata, wr ? 32'h0 : rdata);
    chk({tag, ".rsp_error"}, rsp_error, serr);
    chk({tag, ".done_sel"}, pSel, 0);
    chk({tag, ".done_en"}, pEnable, 0);
    chk({tag, ".done_ready"}, cmd_ready, 1);
    chk({tag, ".done_addr"}, pAddr, addr);
    @(negedge pClk);
    chk({tag, ".rsp_pulse"}, rsp_valid, 0);
    chk({tag, ".rdata_hold"}, rsp_rdata, wr ? 32'h0 : rdata);
    chk({tag, ".err_hold"}, rsp_error, serr);
  endtask

  initial begin
    repeat (2) @(negedge pClk);
    chk("rst.sel", pSel, 0);
    chk("rst.en", pEnable, 0);
    chk("rst.ready", cmd_ready, 0);
    chk("rst.rsp", rsp_valid, 0);
    chk("rst.addr", pAddr, 0);
    chk("rst.rdata", rsp_rdata, 0);
    pReset = 1'b1;
    @(negedge pClk);
    chk("rel.ready", cmd_ready, 1);
    chk("rel.sel", pSel, 0);

    xfer("wr_a5", 1'b1, 32'h0000_0000, 32'h0000_00A5, 32'h0, 0, 1'b0);
    xfer("rd_3c", 1'b0, 32'h0000_0001, 32'h0, 32'h0000_003C, 0, 1'b0);
    xfer("wr_dead", 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h5A5A_5A5A, 0, 1'b0);
    xfer("rd_wait3", 1'b0, 32'h0000_0020, 32'h0, 32'h1234_5678, 3, 1'b0);
    xfer("rd_slverr", 1'b0, 32'h0000_0024, 32'h0, 32'h0000_0055, 1, 1'b1);

    // Back-to-back: cmd_valid stays high across two commands.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h1111;
    @(negedge pClk);
    cmd_write = 1'b0; cmd_addr = 32'h44; cmd_wdata = 32'h2222;
    chk("b2b.a_sel", pSel, 1);
    chk("b2b.a_addr", pAddr, 32'h40);
    pReady = 1'b1; pRdata = 32'h99;
    @(negedge pClk);
    chk("b2b.a_en", pEnable, 1);
    chk("b2b.a_hold", pAddr, 32'h40);
    @(negedge pClk);
    chk("b2b.a_rsp", rsp_valid, 1);
    chk("b2b.a_ready", cmd_ready, 1);
    chk("b2b.a_gap", pSel, 0);
    chk("b2b.a_rdata", rsp_rdata, 0);
    @(negedge pClk);
    cmd_valid = 1'b0;
    chk("b2b.b_sel", pSel, 1);
    chk("b2b.b_en", pEnable, 0);
    chk("b2b.b_addr", pAddr, 32'h44);
    chk("b2b.b_write", pWrite, 0);
    chk("b2b.b_rsp", rsp_valid, 0);
    @(negedge pClk);
    chk("b2b.b_acc", pEnable, 1);
    @(negedge pClk);
    pReady = 1'b0;
    chk("b2b.b_rsp_valid", rsp_valid, 1);
    chk("b2b.b_rdata", rsp_rdata, 32'h99);
    @(negedge pClk);

`ifdef APB_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h90;
    @(negedge pClk);
    cmd_valid = 1'b0; pReady = 1'b0; pRdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 16; i++) begin
      @(negedge pClk);
      chk("to.wait_en", pEnable, 1);
      chk("to.wait_rsp", rsp_valid, 0);
    end
    @(negedge pClk);
    chk("to.rsp", rsp_valid, 1);
    chk("to.err", rsp_error, 1);
    chk("to.rdata", rsp_rdata, 0);
    chk("to.sel", pSel, 0);
    chk("to.ready", cmd_ready, 1);
    @(negedge pClk);
    xfer("to_edge", 1'b0, 32'h94, 32'h0, 32'h77, 15, 1'b0);
`endif

    // Reset asserted in the middle of ACCESS.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h80;
    @(negedge pClk);
    cmd_valid = 1'b0; pReady = 1'b0;
    @(negedge pClk);
    chk("mid.in_access", pEnable, 1);
    #2 pReset = 1'b0;
    #1;
    chk("mid.sel", pSel, 0);
    chk("mid.en", pEnable, 0);
    chk("mid.ready", cmd_ready, 0);
    chk("mid.addr", pAddr, 0);
    @(negedge pClk);
    chk("mid.no_rsp", rsp_valid, 0);
    pReady = 1'b1;
    pReset = 1'b1;
    @(negedge pClk);
    chk("mid.rel_rsp", rsp_valid, 0);
    chk("mid.rel_ready", cmd_ready, 1);
    chk("mid.rel_sel", pSel, 0);
    pReady = 1'b0;
    xfer("post_rst", 1'b0, 32'h84, 32'h0, 32'h0000_CAFE, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
